// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/decode controller in front of a combinational ALU.
// It accepts one packed instruction per valid/ready handshake and reads
// both operands from a small internal register file (r0 reads as zero).
// The operands are presented to the ALU for exactly one cycle (EXEC).
// The ALU result is then written back to R[rd] and reported for one
// cycle (WB). Only one instruction is in flight at a time, so there are
// no hazards to resolve.
module alu_issue_ctrl #(
  parameter int REG_AW  = 3,
  parameter int NUM_OPS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [4:0]        alu_op,
  output logic [31:0]       alu_in1,
  output logic [31:0]       alu_in2,
  output logic [15:0]       alu_imm,
  output logic [4:0]        alu_sh,
  input  logic [31:0]       alu_result,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [31:0]       wb_data,
  output logic              illegal,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  localparam int NREGS = 2 ** REG_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  // Instruction fields, taken straight from the input word.
  logic [4:0]        f_op;
  logic [REG_AW-1:0] f_rd;
  logic [REG_AW-1:0] f_rs;
  logic [REG_AW-1:0] f_rt;
  logic [1:0]        f_rsv;
  logic [15:0]       f_imm;
  logic              f_legal;

  // Architectural and pipeline state.
  state_e            state_q,    state_d;
  logic [4:0]        alu_op_q,   alu_op_d;
  logic [31:0]       alu_in1_q,  alu_in1_d;
  logic [31:0]       alu_in2_q,  alu_in2_d;
  logic [15:0]       alu_imm_q,  alu_imm_d;
  logic [4:0]        alu_sh_q,   alu_sh_d;
  logic [REG_AW-1:0] rd_q,       rd_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_addr_q,  wb_addr_d;
  logic [31:0]       wb_data_q,  wb_data_d;
  logic              illegal_q,  illegal_d;
  logic [31:0]       regs_q [NREGS];
  logic [31:0]       regs_d [NREGS];

  logic              accept;

  // Split the packed instruction and decide whether it may be issued.
  always_comb begin
    f_op    = instr[31:27];
    f_rd    = REG_AW'(instr[26:24]);
    f_rs    = REG_AW'(instr[23:21]);
    f_rt    = REG_AW'(instr[20:18]);
    f_rsv   = instr[17:16];
    f_imm   = instr[15:0];
    f_legal = ({27'd0, f_op} < 32'(NUM_OPS)) && (f_rsv == 2'b00);
  end

  // Ready is high only in IDLE and is forced low while reset is asserted.
  assign instr_ready = (state_q == IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;

  // Next-state, next-output and register-file update logic.
  always_comb begin
    // NOTE: every _d gets a default first so no path can infer a latch;
    // ALU interface and writeback fields hold unless explicitly updated.
    state_d    = state_q;
    alu_op_d   = alu_op_q;
    alu_in1_d  = alu_in1_q;
    alu_in2_d  = alu_in2_q;
    alu_imm_d  = alu_imm_q;
    alu_sh_d   = alu_sh_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    illegal_d  = 1'b0;
    regs_d     = regs_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (f_legal) begin
            // Operands are read here so they are stable for all of EXEC.
            alu_op_d  = f_op;
            alu_in1_d = regs_q[f_rs];
            alu_in2_d = regs_q[f_rt];
            alu_imm_d = f_imm;
            alu_sh_d  = f_imm[4:0];
            rd_d      = f_rd;
            state_d   = EXEC;
          end else begin
            // Dropped: no state beyond the one-cycle flag changes.
            illegal_d = 1'b1;
          end
        end
      end

      EXEC: begin
        // Sample the ALU at the end of EXEC; r0 is never written.
        if (rd_q != '0) begin
          regs_d[rd_q] = alu_result;
        end
        wb_valid_d = 1'b1;
        wb_addr_d  = rd_q;
        wb_data_d  = alu_result;
        state_d    = WB;
      end

      WB: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Keep r0 constant at zero regardless of the update above.
    regs_d[0] = '0;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_op_q   <= '0;
      alu_in1_q  <= '0;
      alu_in2_q  <= '0;
      alu_imm_q  <= '0;
      alu_sh_q   <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
      // NOTE: this register file is only eight words of flops, and its
      // cleared contents are architecturally visible after reset, so it is
      // reset like any other state rather than left to a RAM's power-up.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge value, independent of statement order.
      state_q    <= state_d;
      alu_op_q   <= alu_op_d;
      alu_in1_q  <= alu_in1_d;
      alu_in2_q  <= alu_in2_d;
      alu_imm_q  <= alu_imm_d;
      alu_sh_q   <= alu_sh_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
      regs_q     <= regs_d;
    end
  end

  assign alu_op   = alu_op_q;
  assign alu_in1  = alu_in1_q;
  assign alu_in2  = alu_in2_q;
  assign alu_imm  = alu_imm_q;
  assign alu_sh   = alu_sh_q;
  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign illegal  = illegal_q;

  // Debug port reads the register file directly; entry 0 is always zero.
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl. A small behavioural ALU drives
// alu_result from the controller's ALU outputs. Every expected value in
// the checks below is a hand-computed constant.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  alu_op;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [15:0] alu_imm;
  logic [4:0]  alu_sh;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int errors = 0;
  int checks = 0;

  alu_issue_ctrl #(.REG_AW(3), .NUM_OPS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_op      (alu_op),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_imm     (alu_imm),
    .alu_sh      (alu_sh),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference ALU: sign-extends the immediate for ADDI, zero-extends for ORI.
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      5'd0: alu_result = alu_in1 + {{16{alu_imm[15]}}, alu_imm};
      5'd1: alu_result = alu_in1 + alu_in2;
      5'd2: alu_result = alu_in1 - alu_in2;
      5'd3: alu_result = alu_in1 | alu_in2;
      5'd4: alu_result = alu_in1 | {16'd0, alu_imm};
      5'd5: alu_result = alu_in2 << alu_sh;
      5'd6: alu_result = alu_in2 >> alu_sh;
      5'd7: alu_result = $signed(alu_in2) >>> alu_sh;
      default: alu_result = 32'd0;
    endcase
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [2:0] rt,
                                     input logic [1:0] rsv, input logic [15:0] imm);
    return {op, rd, rs, rt, rsv, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reg_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Called at a falling edge; returns 1ns after the accepting rising edge.
  task automatic issue(input logic [31:0] ins);
    bit acc;
    acc = 1'b0;
    instr       = ins;
    instr_valid = 1'b1;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = instr_ready;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    #1 instr_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'd0;
    dbg_addr    = 3'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("ready_in_rst", {31'd0, instr_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_alu_op", {27'd0, alu_op}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    for (int a = 0; a < 8; a++) reg_chk("rst_reg", 3'(a), 32'd0);

    // ADDI r1,r0,0xFFFF -> R1 = 0xFFFFFFFF.
    @(negedge clk);
    issue(mk(5'd0, 3'd1, 3'd0, 3'd0, 2'b00, 16'hFFFF));
    @(negedge clk);
    check("addi_exec_op", {27'd0, alu_op}, 32'd0);
    check("addi_exec_in1", alu_in1, 32'd0);
    check("addi_exec_imm", {16'd0, alu_imm}, 32'h0000FFFF);
    check("addi_exec_ready", {31'd0, instr_ready}, 32'd0);
    check("addi_exec_wbv", {31'd0, wb_valid}, 32'd0);
    reg_chk("addi_exec_r1_old", 3'd1, 32'd0);
    @(negedge clk);
    check("addi_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("addi_wb_addr", {29'd0, wb_addr}, 32'd1);
    check("addi_wb_data", wb_data, 32'hFFFFFFFF);
    check("addi_wb_ready", {31'd0, instr_ready}, 32'd0);
    reg_chk("addi_r1", 3'd1, 32'hFFFFFFFF);
    @(negedge clk);
    check("addi_idle_wbv", {31'd0, wb_valid}, 32'd0);
    check("addi_idle_ready", {31'd0, instr_ready}, 32'd1);

    // ADDI r2,r0,5 with SHL r3,r0,r2,imm=4 held valid behind it.
    instr       = mk(5'd0, 3'd2, 3'd0, 3'd0, 2'b00, 16'd5);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr = mk(5'd5, 3'd3, 3'd0, 3'd2, 2'b00, 16'd4);
    @(negedge clk);
    check("addi2_exec_ready", {31'd0, instr_ready}, 32'd0);
    check("addi2_exec_imm", {16'd0, alu_imm}, 32'd5);
    @(negedge clk);
    check("addi2_wb_ready", {31'd0, instr_ready}, 32'd0);
    check("addi2_wb_addr", {29'd0, wb_addr}, 32'd2);
    check("addi2_wb_data", wb_data, 32'd5);
    @(negedge clk);
    check("held_idle_ready", {31'd0, instr_ready}, 32'd1);
    check("held_not_early", {27'd0, alu_op}, 32'd0);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("shl_exec_op", {27'd0, alu_op}, 32'd5);
    check("shl_exec_in2", alu_in2, 32'd5);
    check("shl_exec_sh", {27'd0, alu_sh}, 32'd4);
    @(negedge clk);
    check("shl_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("shl_wb_addr", {29'd0, wb_addr}, 32'd3);
    check("shl_wb_data", wb_data, 32'd80);
    reg_chk("shl_r3", 3'd3, 32'd80);
    @(negedge clk);

    // Illegal opcode 9: dropped, flagged for one cycle.
    issue(mk(5'd9, 3'd5, 3'd1, 3'd1, 2'b00, 16'd1));
    @(negedge clk);
    check("op9_illegal", {31'd0, illegal}, 32'd1);
    check("op9_ready", {31'd0, instr_ready}, 32'd1);
    check("op9_wbv", {31'd0, wb_valid}, 32'd0);
    check("op9_alu_hold", {27'd0, alu_op}, 32'd5);
    @(negedge clk);
    check("op9_illegal_off", {31'd0, illegal}, 32'd0);
    check("op9_wbv_late", {31'd0, wb_valid}, 32'd0);
    reg_chk("op9_r5", 3'd5, 32'd0);

    // Opcode 8 is the first illegal value.
    issue(mk(5'd8, 3'd6, 3'd0, 3'd0, 2'b00, 16'd1));
    @(negedge clk);
    check("op8_illegal", {31'd0, illegal}, 32'd1);
    @(negedge clk);

    // Nonzero reserved bits: dropped even with a legal opcode.
    issue(mk(5'd0, 3'd1, 3'd0, 3'd0, 2'b01, 16'd7));
    @(negedge clk);
    check("rsv_illegal", {31'd0, illegal}, 32'd1);
    check("rsv_wbv", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check("rsv_illegal_off", {31'd0, illegal}, 32'd0);
    check("rsv_wbv_late", {31'd0, wb_valid}, 32'd0);
    reg_chk("rsv_r1", 3'd1, 32'hFFFFFFFF);

    // Opcode 7 (SRA) is the last legal value: SRA r6,r0,r1,imm=4.
    issue(mk(5'd7, 3'd6, 3'd0, 3'd1, 2'b00, 16'd4));
    @(negedge clk);
    check("sra_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    check("sra_wb_valid", {31'd0, wb_valid}, 32'd1);
    reg_chk("sra_r6", 3'd6, 32'hFFFFFFFF);
    @(negedge clk);

    // ADD r0,r1,r1: writeback reported, r0 unchanged.
    issue(mk(5'd1, 3'd0, 3'd1, 3'd1, 2'b00, 16'd0));
    @(negedge clk);
    check("add_exec_in1", alu_in1, 32'hFFFFFFFF);
    check("add_exec_in2", alu_in2, 32'hFFFFFFFF);
    @(negedge clk);
    check("add_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("add_wb_addr", {29'd0, wb_addr}, 32'd0);
    check("add_wb_data", wb_data, 32'hFFFFFFFE);
    reg_chk("add_r0", 3'd0, 32'd0);
    @(negedge clk);

    // SUB r4,r1,r2 aborted by reset during EXEC.
    issue(mk(5'd2, 3'd4, 3'd1, 3'd2, 2'b00, 16'd0));
    @(negedge clk);
    check("sub_exec_op", {27'd0, alu_op}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("abort_wbv", {31'd0, wb_valid}, 32'd0);
    check("abort_ready_rst", {31'd0, instr_ready}, 32'd0);
    check("abort_alu_op", {27'd0, alu_op}, 32'd0);
    reg_chk("abort_r4", 3'd4, 32'd0);
    reg_chk("abort_r1", 3'd1, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    check("post_rst_wbv", {31'd0, wb_valid}, 32'd0);
    reg_chk("post_rst_r4", 3'd4, 32'd0);
    @(negedge clk);
    check("post_rst_wbv2", {31'd0, wb_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
